// File: rtl/mem_access_pkg.sv
// Shared widths, FSM state codes and byte-lane masks for the MEM pipeline stage.
// Lane-mask helpers are shared by the store replicator and the load aligner.
package mem_access_pkg;

    localparam int BUS_W      = 32;
    localparam int REG_ADDR_W = 5;
    localparam int LANES      = 4;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    localparam logic [LANES-1:0] SEL_B0 = 4'b0001;
    localparam logic [LANES-1:0] SEL_B1 = 4'b0010;
    localparam logic [LANES-1:0] SEL_B2 = 4'b0100;
    localparam logic [LANES-1:0] SEL_B3 = 4'b1000;
    localparam logic [LANES-1:0] SEL_H0 = 4'b0011;
    localparam logic [LANES-1:0] SEL_H1 = 4'b1100;
    localparam logic [LANES-1:0] SEL_W  = 4'b1111;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_e;

    // Access size follows the number of enabled lanes; anything odd is a word.
    function automatic mem_size_e sel_size(input logic [LANES-1:0] sel);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) begin
            n = n + {2'b00, sel[i]};
        end
        case (n)
            3'd1:    sel_size = SZ_BYTE;
            3'd2:    sel_size = SZ_HALF;
            default: sel_size = SZ_WORD;
        endcase
    endfunction

    function automatic logic [1:0] lowest_lane(input logic [LANES-1:0] sel);
        lowest_lane = 2'd0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (sel[i]) begin
                lowest_lane = 2'(i);
            end
        end
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Right-justifies the selected byte lanes of RAM read data and extends to a full word.
module mem_load_align
    import mem_access_pkg::*;
(
    input  logic [BUS_W-1:0] rdata_i,
    input  logic [LANES-1:0] sel_i,
    input  logic             sign_ext_i,
    output logic [BUS_W-1:0] load_o
);

    logic [1:0]       lane;
    logic [BUS_W-1:0] shifted;
    logic             ext_bit;

    always_comb begin
        lane    = lowest_lane(sel_i);
        shifted = rdata_i >> {lane, 3'b000};
        ext_bit = 1'b0;
        load_o  = rdata_i;
        case (sel_size(sel_i))
            SZ_BYTE: begin
                ext_bit = sign_ext_i & shifted[7];
                load_o  = {{24{ext_bit}}, shifted[7:0]};
            end
            SZ_HALF: begin
                ext_bit = sign_ext_i & shifted[15];
                load_o  = {{16{ext_bit}}, shifted[15:0]};
            end
            default: load_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM stage: ready-based RAM handshake with stall and timeout abort, load alignment,
// store lane replication, and the registered write-back bundle for WB.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read_flag_in,
    input  logic                  mem_write_flag_in,
    input  logic                  mem_sign_ext_flag_in,
    input  logic [LANES-1:0]      mem_sel_in,
    input  logic [DATA_W-1:0]     mem_write_data_in,
    input  logic [DATA_W-1:0]     result_in,
    input  logic                  reg_write_en_in,
    input  logic [REG_ADDR_W-1:0] reg_write_addr_in,
    input  logic [DATA_W-1:0]     current_pc_addr_in,
    output logic                  ram_en,
    output logic [LANES-1:0]      ram_we,
    output logic [DATA_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata,
    input  logic                  ram_ready,
    output logic                  stall_req,
    output logic                  mem_load_flag,
    output logic                  bus_err,
    output logic [DATA_W-1:0]     result_out,
    output logic                  reg_write_en_out,
    output logic [REG_ADDR_W-1:0] reg_write_addr_out,
    output logic [DATA_W-1:0]     current_pc_addr_out,
    output mem_state_e            mem_state_o
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    mem_state_e            state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  bus_err_q;
    logic [DATA_W-1:0]     result_q;
    logic                  reg_we_q;
    logic [REG_ADDR_W-1:0] reg_addr_q;
    logic [DATA_W-1:0]     pc_q;

    logic                  mem_op;
    logic                  is_store;
    logic                  is_load;
    logic                  timeout_hit;
    logic                  advance;
    logic [DATA_W-1:0]     load_val;
    logic [DATA_W-1:0]     wb_result_d;
    logic                  wb_we_d;

    mem_load_align u_load_align (
        .rdata_i    (ram_rdata),
        .sel_i      (mem_sel_in),
        .sign_ext_i (mem_sign_ext_flag_in),
        .load_o     (load_val)
    );

    // A read that is also flagged as a write is handled as a store.
    assign mem_op   = (mem_read_flag_in | mem_write_flag_in) & (|mem_sel_in);
    assign is_store = mem_op & mem_write_flag_in;
    assign is_load  = mem_op & ~mem_write_flag_in;

    assign timeout_hit = (state_q == MEM_WAIT) && (TIMEOUT != 0) && (cnt_q == TIMEOUT_C);
    assign advance     = ~mem_op | ram_ready;

    assign ram_en        = rst_n & mem_op;
    assign ram_we        = (rst_n & is_store) ? mem_sel_in : '0;
    assign stall_req     = rst_n & mem_op & ~ram_ready & ~timeout_hit;
    assign ram_addr      = {result_in[DATA_W-1:2], 2'b00};
    assign mem_load_flag = mem_read_flag_in;

    always_comb begin
        case (sel_size(mem_sel_in))
            SZ_BYTE: ram_wdata = {4{mem_write_data_in[7:0]}};
            SZ_HALF: ram_wdata = {2{mem_write_data_in[15:0]}};
            default: ram_wdata = mem_write_data_in;
        endcase
    end

    // A load with an empty lane mask never touches the RAM and writes back zero.
    always_comb begin
        wb_result_d = result_in;
        wb_we_d     = reg_write_en_in;
        if (is_load) begin
            wb_result_d = load_val;
        end else if (mem_read_flag_in && !mem_write_flag_in && mem_sel_in == '0) begin
            wb_result_d = '0;
        end
        if (is_store) begin
            wb_we_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= MEM_IDLE;
            cnt_q      <= '0;
            bus_err_q  <= 1'b0;
            result_q   <= '0;
            reg_we_q   <= 1'b0;
            reg_addr_q <= '0;
            pc_q       <= '0;
        end else begin
            bus_err_q <= 1'b0;
            if (advance) begin
                state_q    <= MEM_IDLE;
                cnt_q      <= '0;
                result_q   <= wb_result_d;
                reg_we_q   <= wb_we_d;
                reg_addr_q <= reg_write_addr_in;
                pc_q       <= current_pc_addr_in;
            end else if (timeout_hit) begin
                state_q    <= MEM_IDLE;
                cnt_q      <= '0;
                bus_err_q  <= 1'b1;
                result_q   <= '0;
                reg_we_q   <= 1'b0;
                reg_addr_q <= reg_write_addr_in;
                pc_q       <= current_pc_addr_in;
            end else begin
                // Stalled: WB sees a bubble while the access is outstanding.
                reg_we_q <= 1'b0;
                if (state_q == MEM_IDLE) begin
                    state_q <= MEM_WAIT;
                    cnt_q   <= CNT_W'(1);
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign bus_err             = bus_err_q;
    assign result_out          = result_q;
    assign reg_write_en_out    = reg_we_q;
    assign reg_write_addr_out  = reg_addr_q;
    assign current_pc_addr_out = pc_q;
    assign mem_state_o         = state_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for the MEM stage: scoreboard of expected write-back bundles
// {we, rd, result} pushed at issue and popped at the write-back edge.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        mem_read_flag_in;
    logic        mem_write_flag_in;
    logic        mem_sign_ext_flag_in;
    logic [3:0]  mem_sel_in;
    logic [31:0] mem_write_data_in;
    logic [31:0] result_in;
    logic        reg_write_en_in;
    logic [4:0]  reg_write_addr_in;
    logic [31:0] current_pc_addr_in;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ready;
    logic        stall_req;
    logic        mem_load_flag;
    logic        bus_err;
    logic [31:0] result_out;
    logic        reg_write_en_out;
    logic [4:0]  reg_write_addr_out;
    logic [31:0] current_pc_addr_out;
    mem_state_e  mem_state_o;

    logic [37:0] exp_q[$];
    logic [37:0] exp_v;
    logic [37:0] got_v;
    int          n_cmp;
    int          n_err;

    mem_access #(.DATA_W(32), .TIMEOUT(4)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .mem_read_flag_in     (mem_read_flag_in),
        .mem_write_flag_in    (mem_write_flag_in),
        .mem_sign_ext_flag_in (mem_sign_ext_flag_in),
        .mem_sel_in           (mem_sel_in),
        .mem_write_data_in    (mem_write_data_in),
        .result_in            (result_in),
        .reg_write_en_in      (reg_write_en_in),
        .reg_write_addr_in    (reg_write_addr_in),
        .current_pc_addr_in   (current_pc_addr_in),
        .ram_en               (ram_en),
        .ram_we               (ram_we),
        .ram_addr             (ram_addr),
        .ram_wdata            (ram_wdata),
        .ram_rdata            (ram_rdata),
        .ram_ready            (ram_ready),
        .stall_req            (stall_req),
        .mem_load_flag        (mem_load_flag),
        .bus_err              (bus_err),
        .result_out           (result_out),
        .reg_write_en_out     (reg_write_en_out),
        .reg_write_addr_out   (reg_write_addr_out),
        .current_pc_addr_out  (current_pc_addr_out),
        .mem_state_o          (mem_state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- drivers ----------------
    task automatic drive_op(input logic rd_f, input logic wr_f, input logic sgn,
                            input logic [3:0] sel, input logic [31:0] wdata,
                            input logic [31:0] res, input logic we,
                            input logic [4:0] rd, input logic [31:0] pc);
        mem_read_flag_in     = rd_f;
        mem_write_flag_in    = wr_f;
        mem_sign_ext_flag_in = sgn;
        mem_sel_in           = sel;
        mem_write_data_in    = wdata;
        result_in            = res;
        reg_write_en_in      = we;
        reg_write_addr_in    = rd;
        current_pc_addr_in   = pc;
    endtask

    task automatic drive_idle();
        drive_op(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        ram_ready = 1'b0;
        ram_rdata = 32'h0;
    endtask

    // Reference load extraction, written per lane mask.
    function automatic logic [31:0] model_load(input logic [3:0] sel, input logic sgn,
                                               input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'h0;
        h = 16'h0;
        case (sel)
            4'b0001: b = d[7:0];
            4'b0010: b = d[15:8];
            4'b0100: b = d[23:16];
            4'b1000: b = d[31:24];
            4'b0011: h = d[15:0];
            4'b1100: h = d[31:16];
            default: ;
        endcase
        case (sel)
            4'b0001, 4'b0010, 4'b0100, 4'b1000:
                model_load = {{24{sgn & b[7]}}, b};
            4'b0011, 4'b1100:
                model_load = {{16{sgn & h[15]}}, h};
            default: model_load = d;
        endcase
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive_op(1'b1, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h40, 1'b1, 5'd1, 32'h10);
        ram_ready = 1'b0;
        #1;
        n_cmp++;
        if ({ram_en, ram_we, stall_req} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_comb: got en=%b we=%b stall=%b expected all 0", ram_en, ram_we, stall_req);
        end
        tick();
        tick();
        n_cmp++;
        if ({result_out, reg_write_en_out, reg_write_addr_out, current_pc_addr_out, bus_err} !== 71'b0) begin
            n_err++;
            $display("FAIL reset_regs: got res=%h we=%b rd=%0d pc=%h err=%b expected 0", result_out,
                     reg_write_en_out, reg_write_addr_out, current_pc_addr_out, bus_err);
        end
        n_cmp++;
        if (mem_state_o !== MEM_IDLE) begin
            n_err++;
            $display("FAIL reset_state: got %0d expected %0d", mem_state_o, MEM_IDLE);
        end
        drive_idle();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        drive_op(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h1234, 1'b1, 5'd5, 32'h400);
        exp_q.push_back({1'b1, 5'd5, 32'h1234});
        #1;
        n_cmp++;
        if ({stall_req, ram_en} !== 2'b00) begin
            n_err++;
            $display("FAIL alu_stall: got stall=%b en=%b expected 0 0", stall_req, ram_en);
        end
        tick();
        exp_v = exp_q.pop_front();
        got_v = {reg_write_en_out, reg_write_addr_out, result_out};
        n_cmp++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL alu_wb: got %h expected %h", got_v, exp_v);
        end
        n_cmp++;
        if (current_pc_addr_out !== 32'h400) begin
            n_err++;
            $display("FAIL alu_pc: got %h expected %h", current_pc_addr_out, 32'h400);
        end
        drive_idle();
    endtask

    task automatic test_sel_zero();
        drive_op(1'b1, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h777, 1'b1, 5'd6, 32'h404);
        exp_q.push_back({1'b1, 5'd6, 32'h0});
        #1;
        n_cmp++;
        if ({stall_req, ram_en} !== 2'b00) begin
            n_err++;
            $display("FAIL selzero_ram: got stall=%b en=%b expected 0 0", stall_req, ram_en);
        end
        tick();
        exp_v = exp_q.pop_front();
        got_v = {reg_write_en_out, reg_write_addr_out, result_out};
        n_cmp++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL selzero_wb: got %h expected %h", got_v, exp_v);
        end
        drive_idle();
    endtask

    task automatic test_lb_same_cycle();
        drive_op(1'b1, 1'b0, 1'b1, 4'b1000, 32'h0, 32'h103, 1'b1, 5'd7, 32'h408);
        ram_ready = 1'b1;
        ram_rdata = 32'h80FFFFFF;
        exp_q.push_back({1'b1, 5'd7, 32'hFFFFFF80});
        #1;
        n_cmp++;
        if ({stall_req, ram_en, ram_we, mem_load_flag} !== 7'b0100001) begin
            n_err++;
            $display("FAIL lb_ctrl: got stall=%b en=%b we=%b ld=%b expected 0 1 0000 1",
                     stall_req, ram_en, ram_we, mem_load_flag);
        end
        n_cmp++;
        if (ram_addr !== 32'h100) begin
            n_err++;
            $display("FAIL lb_addr: got %h expected %h", ram_addr, 32'h100);
        end
        tick();
        exp_v = exp_q.pop_front();
        got_v = {reg_write_en_out, reg_write_addr_out, result_out};
        n_cmp++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL lb_wb: got %h expected %h", got_v, exp_v);
        end
        drive_idle();
    endtask

    task automatic test_lhu_wait();
        int  stall_cnt;
        bit  done;
        stall_cnt = 0;
        done = 0;
        drive_op(1'b1, 1'b0, 1'b0, 4'b1100, 32'h0, 32'h102, 1'b1, 5'd9, 32'h40C);
        exp_q.push_back({1'b1, 5'd9, 32'h0000BEEF});
        for (int c = 0; c < 20 && !done; c++) begin
            if (c == 3) begin
                ram_ready = 1'b1;
                ram_rdata = 32'hBEEF0000;
            end
            #1;
            if (stall_req) stall_cnt++;
            if (c == 2) begin
                n_cmp++;
                if ({ram_en, mem_state_o} !== {1'b1, MEM_WAIT}) begin
                    n_err++;
                    $display("FAIL lhu_waiting: got en=%b state=%0d expected 1 1", ram_en, mem_state_o);
                end
            end
            if (ram_ready) done = 1;
            tick();
        end
        n_cmp++;
        if (!done || stall_cnt != 3) begin
            n_err++;
            $display("FAIL lhu_stall: got %0d stall cycles (done=%0d) expected 3", stall_cnt, done);
        end
        exp_v = exp_q.pop_front();
        got_v = {reg_write_en_out, reg_write_addr_out, result_out};
        n_cmp++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL lhu_wb: got %h expected %h", got_v, exp_v);
        end
        n_cmp++;
        if (mem_state_o !== MEM_IDLE) begin
            n_err++;
            $display("FAIL lhu_state: got %0d expected %0d", mem_state_o, MEM_IDLE);
        end
        drive_idle();
    endtask

    task automatic test_sb();
        drive_op(1'b0, 1'b1, 1'b0, 4'b0010, 32'h000000AB, 32'h101, 1'b1, 5'd3, 32'h410);
        ram_ready = 1'b1;
        exp_q.push_back({1'b0, 5'd3, 32'h101});
        #1;
        n_cmp++;
        if ({ram_en, ram_we, stall_req} !== 6'b1_0010_0) begin
            n_err++;
            $display("FAIL sb_ctrl: got en=%b we=%b stall=%b expected 1 0010 0", ram_en, ram_we, stall_req);
        end
        n_cmp++;
        if (ram_wdata !== 32'hABABABAB) begin
            n_err++;
            $display("FAIL sb_wdata: got %h expected %h", ram_wdata, 32'hABABABAB);
        end
        tick();
        exp_v = exp_q.pop_front();
        got_v = {reg_write_en_out, reg_write_addr_out, result_out};
        n_cmp++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL sb_wb: got %h expected %h", got_v, exp_v);
        end
        // Halfword store on the upper lanes, read+write both set -> store.
        drive_op(1'b1, 1'b1, 1'b0, 4'b1100, 32'h0000C0DE, 32'h202, 1'b1, 5'd4, 32'h414);
        ram_ready = 1'b1;
        #1;
        n_cmp++;
        if ({ram_we, ram_wdata} !== {4'b1100, 32'hC0DEC0DE}) begin
            n_err++;
            $display("FAIL sh_lanes: got we=%b wdata=%h expected 1100 c0dec0de", ram_we, ram_wdata);
        end
        tick();
        drive_idle();
    endtask

    task automatic test_back_to_back();
        logic [3:0]  sel_tab[7];
        logic [3:0]  sel;
        logic        sgn;
        logic [31:0] d;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
        sel_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        for (int i = 0; i < 12; i++) begin
            res = $urandom;
            rd  = 5'($urandom_range(0, 31));
            we  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                drive_op(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, res, we, rd, 32'h500 + 32'(i));
                ram_ready = 1'b0;
                exp_q.push_back({we, rd, res});
            end else begin
                sel = sel_tab[$urandom_range(0, 6)];
                sgn = 1'($urandom_range(0, 1));
                d   = $urandom;
                drive_op(1'b1, 1'b0, sgn, sel, 32'h0, res, we, rd, 32'h500 + 32'(i));
                ram_ready = 1'b1;
                ram_rdata = d;
                exp_q.push_back({we, rd, model_load(sel, sgn, d)});
            end
            tick();
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL b2b_queue: got empty queue expected an entry");
            end else begin
                exp_v = exp_q.pop_front();
                got_v = {reg_write_en_out, reg_write_addr_out, result_out};
                n_cmp++;
                if (got_v !== exp_v) begin
                    n_err++;
                    $display("FAIL b2b_wb[%0d]: got %h expected %h", i, got_v, exp_v);
                end
            end
        end
        drive_idle();
    endtask

    task automatic test_timeout();
        int stall_cnt;
        bit seen;
        stall_cnt = 0;
        seen = 0;
        drive_op(1'b1, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h200, 1'b1, 5'd4, 32'h600);
        ram_ready = 1'b0;
        exp_q.push_back({1'b0, 5'd4, 32'h0});
        for (int c = 0; c < 20 && !seen; c++) begin
            #1;
            if (stall_req) stall_cnt++;
            tick();
            if (bus_err) seen = 1;
        end
        n_cmp++;
        if (!seen || stall_cnt != 4) begin
            n_err++;
            $display("FAIL timeout_stall: got %0d stall cycles (bus_err=%0d) expected 4", stall_cnt, seen);
        end
        exp_v = exp_q.pop_front();
        got_v = {reg_write_en_out, reg_write_addr_out, result_out};
        n_cmp++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL timeout_wb: got %h expected %h", got_v, exp_v);
        end
        drive_idle();
        tick();
        n_cmp++;
        if (bus_err !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_pulse: got bus_err=%b expected 0", bus_err);
        end
    endtask

    task automatic test_reset_mid_wait();
        drive_op(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'hCAFE, 1'b1, 5'd2, 32'h700);
        tick();
        drive_op(1'b1, 1'b0, 1'b1, 4'b0001, 32'h0, 32'h300, 1'b1, 5'd8, 32'h704);
        ram_ready = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({mem_state_o, result_out} !== {MEM_WAIT, 32'hCAFE}) begin
            n_err++;
            $display("FAIL midwait_pre: got state=%0d res=%h expected 1 0000cafe", mem_state_o, result_out);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ram_en, stall_req} !== 2'b00) begin
            n_err++;
            $display("FAIL midwait_comb: got en=%b stall=%b expected 0 0", ram_en, stall_req);
        end
        tick();
        n_cmp++;
        if ({mem_state_o, result_out, reg_write_en_out, bus_err} !== {MEM_IDLE, 32'h0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL midwait_regs: got state=%0d res=%h we=%b err=%b expected 0 0 0 0",
                     mem_state_o, result_out, reg_write_en_out, bus_err);
        end
        drive_idle();
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if ({bus_err, mem_state_o} !== {1'b0, MEM_IDLE}) begin
            n_err++;
            $display("FAIL midwait_post: got err=%b state=%0d expected 0 0", bus_err, mem_state_o);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive_idle();
        test_reset();
        test_alu();
        test_sel_zero();
        test_lb_same_cycle();
        test_lhu_wait();
        test_sb();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
